// File: rtl/eth_gmii_rx_framer.sv
// ============================================================================
// eth_gmii_rx_framer : GMII receive framer with store-and-forward FIFO
//   Strips preamble/SFD, length/error/overflow checks, commit-or-rollback FIFO.
//   Optional CRC-32 check enabled by defining ETH_CRC_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module eth_gmii_rx_framer #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64,
  parameter int FIFO_AW = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        frm_done,
  output logic [15:0] frm_len,
  output logic [3:0]  frm_status,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [15:0]        max_len_c = 16'(MAX_LEN);
  localparam logic [15:0]        min_len_c = 16'(MIN_LEN);
  localparam logic [15:0]        ovr_len_c = 16'(MAX_LEN + 1);
  localparam logic [FIFO_AW-1:0] ptr_one   = {{(FIFO_AW-1){1'b0}}, 1'b1};

  state_t             state;
  logic [8:0]         mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] cmt_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [15:0]        len;
  logic               st_rx;
  logic               st_len;
  logic               st_ovf;
  logic               armed;
  logic [7:0]         last_byte;

  logic full;
  logic at_max;
  logic short_frm;
  logic crc_ok;
  logic data_wr;
  logic end_good;

  assign full      = (wr_ptr + ptr_one) == rd_ptr;
  assign at_max    = (len == max_len_c);
  assign short_frm = (len < min_len_c);
  assign data_wr   = (state == DATA) && rx_dv && !at_max && !full;
  assign end_good  = (state == DATA) && !rx_dv && !st_rx && !st_ovf && !st_len
                     && !short_frm && crc_ok;

`ifdef ETH_CRC_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      crc <= 32'hFFFF_FFFF;
    else if (state == PREAMBLE && rx_dv && rx_data == 8'hD5)
      crc <= 32'hFFFF_FFFF;
    else if (state == DATA && rx_dv)
      crc <= crc_byte(crc, rx_data);
  end

  // Reflected register: DEBB20E3 is the bit-reversed form of residue C704DD7B.
  assign crc_ok = (crc == 32'hDEBB_20E3);
`else
  assign crc_ok = 1'b1;
`endif

  // Bytes land at the speculative pointer; the final byte is rewritten with
  // its last flag in the commit cycle, before it becomes readable.
  always_ff @(posedge clk) begin
    if (data_wr)
      mem[wr_ptr] <= {1'b0, rx_data};
    else if (end_good)
      mem[wr_ptr - ptr_one] <= {1'b1, last_byte};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      cmt_ptr    <= '0;
      rd_ptr     <= '0;
      len        <= '0;
      st_rx      <= 1'b0;
      st_len     <= 1'b0;
      st_ovf     <= 1'b0;
      armed      <= 1'b0;
      last_byte  <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frm_done   <= 1'b0;
      frm_len    <= '0;
      frm_status <= '0;
      drop_cnt   <= '0;
    end else begin
      frm_done <= 1'b0;
      // After reset, a frame already in flight is ignored until rx_dv drops.
      if (!rx_dv)
        armed <= 1'b1;

      case (state)
        IDLE: begin
          len    <= '0;
          st_rx  <= 1'b0;
          st_len <= 1'b0;
          st_ovf <= 1'b0;
          if (rx_dv && armed) begin
            if (rx_data == 8'h55) begin
              state <= PREAMBLE;
            end else begin
              state  <= DROP;
              st_len <= 1'b1;
            end
          end
        end

        PREAMBLE: begin
          if (!rx_dv) begin
            state <= IDLE;
          end else if (rx_data == 8'hD5) begin
            state <= DATA;
          end else if (rx_data != 8'h55) begin
            state  <= DROP;
            st_len <= 1'b1;
          end
        end

        DATA: begin
          if (rx_dv) begin
            if (rx_er)
              st_rx <= 1'b1;
            if (at_max) begin
              len    <= ovr_len_c;
              st_len <= 1'b1;
              state  <= DROP;
            end else begin
              len <= len + 16'd1;
              if (full) begin
                st_ovf <= 1'b1;
                state  <= DROP;
              end else begin
                wr_ptr    <= wr_ptr + ptr_one;
                last_byte <= rx_data;
              end
            end
          end else begin
            frm_done   <= 1'b1;
            frm_len    <= len;
            frm_status <= {st_ovf, ~crc_ok, st_len | short_frm, st_rx};
            state      <= IDLE;
            if (end_good) begin
              cmt_ptr <= wr_ptr;
            end else begin
              wr_ptr <= cmt_ptr;
              if (drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            end
          end
        end

        DROP: begin
          if (!rx_dv) begin
            frm_done   <= 1'b1;
            frm_len    <= len;
            frm_status <= {st_ovf, 1'b0, st_len | short_frm, st_rx};
            wr_ptr     <= cmt_ptr;
            state      <= IDLE;
            if (drop_cnt != 16'hFFFF)
              drop_cnt <= drop_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase

      // Output register reloads only when empty or accepted; holds under stall.
      if (!m_valid || m_ready) begin
        if (rd_ptr != cmt_ptr) begin
          m_valid <= 1'b1;
          m_data  <= mem[rd_ptr][7:0];
          m_last  <= mem[rd_ptr][8];
          rd_ptr  <= rd_ptr + ptr_one;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eth_gmii_rx_framer.sv
// ============================================================================
// tb_eth_gmii_rx_framer : directed table-driven bench for eth_gmii_rx_framer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_eth_gmii_rx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        frm_done;
  logic [15:0] frm_len;
  logic [3:0]  frm_status;
  logic [15:0] drop_cnt;

  eth_gmii_rx_framer dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frm_done(frm_done), .frm_len(frm_len), .frm_status(frm_status),
    .drop_cnt(drop_cnt)
  );

  always #4 clk = ~clk;

  typedef struct {
    int         n;
    int         er_at;
    bit         flip;
    int         mode;
    int         exp_len;
    logic [3:0] exp_st;
    bit         deliver;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         exp_drop = 0;
  logic [8:0] got_q[$];
  logic [7:0] cur[$];
  logic [7:0] f1[$];
  vec_t       tbl[10];

  always @(negedge clk) begin
    if (frm_done) done_cnt++;
    if (m_valid && m_ready) got_q.push_back({m_last, m_data});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    @(posedge clk);
    #1;
    rx_data = d;
    rx_dv   = dv;
    rx_er   = er;
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // mode 0: normal preamble, 1: non-55 first byte, 2: bad SFD
  task automatic send_frame(input int n, input int er_at, input bit flip, input int mode);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    cur.delete();
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < n - 4; i++) begin
      b = 8'(i * 13 + n);
      cur.push_back(b);
      crc = crc_upd(crc, b);
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) cur.push_back(fcs[8*k +: 8]);
    if (flip) cur[n-1] = cur[n-1] ^ 8'h10;
    if (mode == 1) begin
      drive(8'h12, 1'b1, 1'b0);
    end else begin
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
      drive((mode == 2) ? 8'h77 : 8'hD5, 1'b1, 1'b0);
    end
    for (int i = 0; i < n; i++) drive(cur[i], 1'b1, (i == er_at));
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frm_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_payload(input string nm, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++)
      if (got_q[i] !== {(i == n - 1), cur[i]}) errs++;
    chk(nm, errs, 0);
  endtask

  initial begin
    bit seen;
    int d0;
    int errs;

    tbl[0] = '{64,   -1, 1'b0, 0, 64,   4'b0000, 1'b1};
    tbl[1] = '{100,  -1, 1'b0, 0, 100,  4'b0000, 1'b1};
    tbl[2] = '{1518, -1, 1'b0, 0, 1518, 4'b0000, 1'b1};
    tbl[3] = '{1519, -1, 1'b0, 0, 1519, 4'b0010, 1'b0};
    tbl[4] = '{2000, -1, 1'b0, 0, 1519, 4'b0010, 1'b0};
    tbl[5] = '{63,   -1, 1'b0, 0, 63,   4'b0010, 1'b0};
    tbl[6] = '{100,  49, 1'b0, 0, 100,  4'b0001, 1'b0};
`ifdef ETH_CRC_CHECK_EN
    tbl[7] = '{64,   -1, 1'b1, 0, 64,   4'b0100, 1'b0};
`else
    tbl[7] = '{64,   -1, 1'b1, 0, 64,   4'b0000, 1'b1};
`endif
    tbl[8] = '{10,   -1, 1'b0, 1, 0,    4'b0010, 1'b0};
    tbl[9] = '{10,   -1, 1'b0, 2, 0,    4'b0010, 1'b0};

    rst = 1'b1; rx_data = 8'h00; rx_dv = 1'b0; rx_er = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid",    m_valid,    0);
    chk("rst_m_last",     m_last,     0);
    chk("rst_m_data",     m_data,     0);
    chk("rst_frm_done",   frm_done,   0);
    chk("rst_frm_len",    frm_len,    0);
    chk("rst_frm_status", frm_status, 0);
    chk("rst_drop_cnt",   drop_cnt,   0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    for (int v = 0; v < 10; v++) begin
      got_q.delete();
      send_frame(tbl[v].n, tbl[v].er_at, tbl[v].flip, tbl[v].mode);
      wait_done(seen);
      chk("done_seen", seen, 1);
      chk("frm_len", frm_len, tbl[v].exp_len);
      chk("frm_status", frm_status, tbl[v].exp_st);
      if (tbl[v].deliver) begin
        chk("m_valid_at_done", m_valid, 0);
        @(negedge clk);
        chk("m_valid_after_done", m_valid, 1);
      end else begin
        exp_drop++;
      end
      chk("drop_cnt", drop_cnt, exp_drop);
      repeat (tbl[v].n + 20) @(negedge clk);
      chk("byte_count", got_q.size(), tbl[v].deliver ? tbl[v].n : 0);
      if (tbl[v].deliver) check_payload("payload", tbl[v].n);
    end

    // Preamble cut short: back to idle silently.
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);

    // Overflow with the output stalled; the first frame must survive.
    got_q.delete();
    @(posedge clk); #1 m_ready = 1'b0;
    send_frame(1518, -1, 1'b0, 0);
    f1 = cur;
    wait_done(seen);
    chk("stall_f1_done", seen, 1);
    chk("stall_f1_status", frm_status, 4'b0000);
    repeat (3) @(negedge clk);
    chk("stall_valid", m_valid, 1);
    chk("stall_data", m_data, f1[0]);
    send_frame(1518, -1, 1'b0, 0);
    wait_done(seen);
    chk("ovf_done", seen, 1);
    chk("ovf_status", frm_status, 4'b1000);
    exp_drop++;
    chk("ovf_drop_cnt", drop_cnt, exp_drop);
    chk("stall_hold", {m_valid, m_last, m_data}, {2'b10, f1[0]});
    @(posedge clk); #1 m_ready = 1'b1;
    repeat (1600) @(negedge clk);
    chk("ovf_f1_count", got_q.size(), 1518);
    cur = f1;
    check_payload("ovf_f1_payload", 1518);

    // Reset in the middle of a 200-byte frame; tail keeps arriving after release.
    got_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      drive(8'(i + 1), 1'b1, 1'b0);
      if (i == 20) rst = 1'b1;
      if (i == 22) rst = 1'b0;
    end
    drive(8'h00, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_no_bytes", got_q.size(), 0);
    exp_drop = 0;
    send_frame(64, -1, 1'b0, 0);
    wait_done(seen);
    chk("post_rst_done", seen, 1);
    chk("post_rst_len", frm_len, 64);
    chk("post_rst_status", frm_status, 4'b0000);
    chk("post_rst_drop_cnt", drop_cnt, 0);
    repeat (90) @(negedge clk);
    chk("post_rst_count", got_q.size(), 64);
    errs = 0;
    check_payload("post_rst_payload", 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
